// File: rtl/lpf_decim_pkg.sv
// Shared DSP package: stream width, the legal decimation factors and the
// elaboration-time helpers used by the decimator and its phase counter.
package lpf_decim_pkg;

    // Width of every sample on the filter chain stream.
    localparam int DSP_DATA_W = 18;

    // Control view of the decimator: the state is implied by the phase count.
    typedef enum logic {
        CTRL_ACCUM,
        CTRL_DUMP
    } ctrl_e;

    // Ceiling log2, used to derive the phase width and the mean shift.
    function automatic int dsp_clog2(input int value);
        int result;
        result = 0;
        for (int span = 1; span < value; span = span * 2) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Legal decimation factors are exactly 2, 4, 8 and 16; the mean is then a
    // pure shift and the accumulator width follows directly from the factor.
    function automatic bit is_legal_ratio(input int ratio);
        return (ratio == 2) || (ratio == 4) || (ratio == 8) || (ratio == 16);
    endfunction

endpackage

// File: rtl/lpf_decim_if.sv
// Stream interface between the low-pass stage, the decimator and its consumer.
// The master side feeds samples and restart; the slave side is the decimator.
interface lpf_decim_if
    import lpf_decim_pkg::*;
#(
    parameter int RATIO = 8
);
    localparam int SHIFT = dsp_clog2(RATIO);

    logic                  clr;
    logic [DSP_DATA_W-1:0] din;
    logic                  din_valid;
    logic [DSP_DATA_W-1:0] dout;
    logic                  dout_valid;
    logic [SHIFT-1:0]      phase;

    modport master (
        output clr,
        output din,
        output din_valid,
        input  dout,
        input  dout_valid,
        input  phase
    );

    modport slave (
        input  clr,
        input  din,
        input  din_valid,
        output dout,
        output dout_valid,
        output phase
    );

endinterface

// File: rtl/dsp_phase_cnt.sv
// Modulo-N phase counter with enable, synchronous clear and a terminal-count
// flag. Shared by the decimator and the future interpolator stages.
module dsp_phase_cnt #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance and wrap at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    // Count register, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/lpf_decim.sv
// Integrate-and-dump decimator: sums RATIO accepted samples and emits their
// rounded mean (half up) with a one-cycle strobe, then restarts from zero.
module lpf_decim
    import lpf_decim_pkg::*;
#(
    parameter int RATIO = 8
) (
    input  logic       clk,
    input  logic       rst,
    lpf_decim_if.slave bus
);

    localparam int SHIFT = dsp_clog2(RATIO);
    localparam int ACC_W = DSP_DATA_W + SHIFT;
    localparam logic [ACC_W-1:0] ROUND_HALF = ACC_W'(RATIO / 2);

    generate
        if (!is_legal_ratio(RATIO)) begin : g_bad_ratio
            $fatal(1, "lpf_decim: RATIO must be 2, 4, 8 or 16");
        end
    endgenerate

    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      acc_d;
    logic [DSP_DATA_W-1:0] dout_q;
    logic [DSP_DATA_W-1:0] dout_d;
    logic                  dout_valid_q;
    logic                  dout_valid_d;
    logic [ACC_W-1:0]      sum;
    logic [ACC_W-1:0]      rounded_sum;
    logic [SHIFT-1:0]      phase_w;
    logic                  phase_tc;
    logic                  accept;
    ctrl_e                 ctrl;

    // A sample counts only when valid and not overridden by a restart.
    assign accept = bus.din_valid & ~bus.clr;

    dsp_phase_cnt #(
        .N (RATIO),
        .W (SHIFT)
    ) u_phase_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (accept),
        .clr_i (bus.clr),
        .cnt_o (phase_w),
        .tc_o  (phase_tc)
    );

    assign ctrl = phase_tc ? CTRL_DUMP : CTRL_ACCUM;

    // Accumulate in ACCUM; in DUMP emit the rounded mean and restart from zero.
    always_comb begin
        sum          = acc_q + ACC_W'(bus.din);
        rounded_sum  = sum + ROUND_HALF;
        acc_d        = acc_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (bus.clr) begin
            acc_d = '0;
        end else if (accept) begin
            unique case (ctrl)
                CTRL_ACCUM: begin
                    acc_d = sum;
                end
                CTRL_DUMP: begin
                    acc_d        = '0;
                    dout_d       = DSP_DATA_W'(rounded_sum >> SHIFT);
                    dout_valid_d = 1'b1;
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
    end

    // Accumulator and output registers; reset drops any partial sum at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.phase      = phase_w;

endmodule

// File: tb/tb_lpf_decim.sv
// Self-checking bench for lpf_decim: a directed vector table on the RATIO=8
// instance plus hand-written sequences for reset, gaps, restart and RATIO=16.
module tb_lpf_decim;

    logic clk;
    logic rst;

    lpf_decim_if #(.RATIO(8))  if8 ();
    lpf_decim_if #(.RATIO(16)) if16 ();

    lpf_decim #(.RATIO(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    lpf_decim #(.RATIO(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    typedef struct {
        string       name;
        logic        clr;
        logic [17:0] din;
        logic        valid;
        logic [17:0] expDout;
        logic        expValid;
        logic [4:0]  expPhase;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one directed vector with its hand-computed expectation.
    task automatic addVec(input string name, input logic clr, input logic [17:0] din,
                          input logic valid, input logic [17:0] expDout,
                          input logic expValid, input logic [4:0] expPhase);
        vec_t v;
        v.name     = name;
        v.clr      = clr;
        v.din      = din;
        v.valid    = valid;
        v.expDout  = expDout;
        v.expValid = expValid;
        v.expPhase = expPhase;
        vecs.push_back(v);
    endtask

    // Drive one cycle on the selected instance, then settle just past the edge.
    task automatic applyStimulus(input bit use16, input logic clr,
                                 input logic [17:0] din, input logic valid);
        @(negedge clk);
        if8.clr        = use16 ? 1'b0 : clr;
        if8.din        = use16 ? 18'd0 : din;
        if8.din_valid  = use16 ? 1'b0 : valid;
        if16.clr       = use16 ? clr : 1'b0;
        if16.din       = use16 ? din : 18'd0;
        if16.din_valid = use16 ? valid : 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name,
                               input logic [17:0] actDout, input logic actValid,
                               input logic [4:0] actPhase,
                               input logic [17:0] expDout, input logic expValid,
                               input logic [4:0] expPhase);
        checks = checks + 1;
        if (actDout !== expDout) begin
            errors = errors + 1;
            $display("[TB] FAIL %s dout: got %0d expected %0d", name, actDout, expDout);
        end
        checks = checks + 1;
        if (actValid !== expValid) begin
            errors = errors + 1;
            $display("[TB] FAIL %s dout_valid: got %0b expected %0b", name, actValid, expValid);
        end
        checks = checks + 1;
        if (actPhase !== expPhase) begin
            errors = errors + 1;
            $display("[TB] FAIL %s phase: got %0d expected %0d", name, actPhase, expPhase);
        end
    endtask

    task automatic check8(input string name, input logic [17:0] expDout,
                          input logic expValid, input logic [4:0] expPhase);
        checkOutput(name, if8.dout, if8.dout_valid, {2'b00, if8.phase},
                    expDout, expValid, expPhase);
    endtask

    task automatic check16(input string name, input logic [17:0] expDout,
                           input logic expValid, input logic [4:0] expPhase);
        checkOutput(name, if16.dout, if16.dout_valid, {1'b0, if16.phase},
                    expDout, expValid, expPhase);
    endtask

    initial begin
        int gaps;
        rst            = 1'b1;
        if8.clr        = 1'b0;
        if8.din        = '0;
        if8.din_valid  = 1'b0;
        if16.clr       = 1'b0;
        if16.din       = '0;
        if16.din_valid = 1'b0;

        // Vector table for the RATIO=8 instance.
        // Constant 1000: strobe after the 8th and 16th samples.
        for (int k = 1; k <= 16; k++) begin
            addVec($sformatf("const1000 k=%0d", k), 1'b0, 18'd1000, 1'b1,
                   (k >= 8) ? 18'd1000 : 18'd0, (k % 8) == 0, 5'(k % 8));
        end
        // Seven zeros then 4: (4+4)>>3 = 1.
        for (int k = 1; k <= 8; k++) begin
            addVec($sformatf("round4 k=%0d", k), 1'b0, (k == 8) ? 18'd4 : 18'd0, 1'b1,
                   (k == 8) ? 18'd1 : 18'd1000, k == 8, 5'(k % 8));
        end
        // Seven zeros then 3: (3+4)>>3 = 0.
        for (int k = 1; k <= 8; k++) begin
            addVec($sformatf("round3 k=%0d", k), 1'b0, (k == 8) ? 18'd3 : 18'd0, 1'b1,
                   (k == 8) ? 18'd0 : 18'd1, k == 8, 5'(k % 8));
        end
        // Full scale: (8*262143+4)>>3 = 262143, no wrap.
        for (int k = 1; k <= 8; k++) begin
            addVec($sformatf("full8 k=%0d", k), 1'b0, 18'd262143, 1'b1,
                   (k == 8) ? 18'd262143 : 18'd0, k == 8, 5'(k % 8));
        end
        // Idle after the dump: strobe lasts one cycle, dout holds.
        addVec("idle after full8", 1'b0, 18'd5, 1'b0, 18'd262143, 1'b0, 5'd0);

        // Reset and idle.
        repeat (2) @(negedge clk);
        #1;
        check8("reset dut8", 18'd0, 1'b0, 5'd0);
        check16("reset dut16", 18'd0, 1'b0, 5'd0);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 1'b0, 18'd1000, 1'b1);
            check8($sformatf("prereset k=%0d", k), 18'd0, 1'b0, 5'(k));
        end
        @(negedge clk);
        if8.din       = 18'd1000;
        if8.din_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check8("async reset", 18'd0, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        check8("reset held", 18'd0, 1'b0, 5'd0);
        @(negedge clk);
        rst           = 1'b0;
        if8.din_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, 1'b0, 18'd1000, 1'b0);
            check8($sformatf("idle k=%0d", k), 18'd0, 1'b0, 5'd0);
        end

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(1'b0, vecs[i].clr, vecs[i].din, vecs[i].valid);
            check8(vecs[i].name, vecs[i].expDout, vecs[i].expValid, vecs[i].expPhase);
        end

        // Valid gaps: phase holds through idle cycles, one strobe with dout=8.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b0, 18'd8, 1'b1);
            check8($sformatf("gap sample k=%0d", k), (k == 8) ? 18'd8 : 18'd262143,
                   k == 8, 5'(k % 8));
            if (k < 8) begin
                gaps = $urandom_range(1, 3);
                for (int g = 0; g < gaps; g++) begin
                    applyStimulus(1'b0, 1'b0, 18'd77, 1'b0);
                    check8($sformatf("gap idle k=%0d g=%0d", k, g), 18'd262143, 1'b0, 5'(k));
                end
            end
        end

        // Restart mid-block: 9999 is dropped and the 500s are forgotten.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b0, 1'b0, 18'd500, 1'b1);
            check8($sformatf("clr pre k=%0d", k), 18'd8, 1'b0, 5'(k));
        end
        applyStimulus(1'b0, 1'b1, 18'd9999, 1'b1);
        check8("clr cycle", 18'd8, 1'b0, 5'd0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b0, 18'd200, 1'b1);
            check8($sformatf("clr post k=%0d", k), (k == 8) ? 18'd200 : 18'd8,
                   k == 8, 5'(k % 8));
        end

        // Restart on what would have been the dump cycle: no strobe.
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b0, 1'b0, 18'd100, 1'b1);
            check8($sformatf("clr dump pre k=%0d", k), 18'd200, 1'b0, 5'(k));
        end
        applyStimulus(1'b0, 1'b1, 18'd100, 1'b1);
        check8("clr on dump", 18'd200, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 18'd0, 1'b0);
        check8("after clr on dump", 18'd200, 1'b0, 5'd0);

        // RATIO=16 full scale: (16*262143+8)>>4 = 262143.
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 1'b0, 18'd262143, 1'b1);
            check16($sformatf("full16 k=%0d", k), (k == 16) ? 18'd262143 : 18'd0,
                    k == 16, 5'(k % 16));
        end
        applyStimulus(1'b1, 1'b0, 18'd0, 1'b0);
        check16("idle after full16", 18'd262143, 1'b0, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
